// File: rtl/rvfi_dmem_check_multi.sv
// Shadow-memory checker for RVFI data-memory traffic over a set of tracked words.
// It flags loads whose bytes disagree with previously stored or observed values.
module rvfi_dmem_check_multi #(
  parameter int XLEN         = 32,
  parameter int NRET         = 1,
  parameter int NWORDS       = 4,
  parameter int INIT_ON_READ = 1,
  parameter int CNT_W        = 16,
  localparam int BYTES = XLEN / 8,
  localparam int CH_W  = (NRET > 1) ? $clog2(NRET) : 1,
  localparam int WD_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [NRET*XLEN-1:0]    rvfi_mem_addr,
  input  logic [NRET*BYTES-1:0]   rvfi_mem_rmask,
  input  logic [NRET*BYTES-1:0]   rvfi_mem_wmask,
  input  logic [NRET*XLEN-1:0]    rvfi_mem_rdata,
  input  logic [NRET*XLEN-1:0]    rvfi_mem_wdata,
  input  logic [NWORDS*XLEN-1:0]  track_addr,
  output logic                    err,
  output logic [CH_W-1:0]         err_chan,
  output logic [WD_W-1:0]         err_word,
  output logic [BYTES-1:0]        err_bmask,
  output logic [XLEN-1:0]         err_expected,
  output logic [XLEN-1:0]         err_actual,
  output logic [CNT_W-1:0]        check_cnt,
  output logic [CNT_W-1:0]        err_cnt
);

  localparam int ADD_W = $clog2(NRET * NWORDS + 1);
  localparam int SUM_W = ((CNT_W > ADD_W) ? CNT_W : ADD_W) + 1;
  localparam logic [XLEN-1:0]  ADDR_MASK = ~(XLEN'(BYTES - 1));
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  logic [XLEN-1:0]  shadow_q [NWORDS];
  logic [BYTES-1:0] known_q  [NWORDS];
  logic [XLEN-1:0]  shadow_nx [NWORDS];
  logic [BYTES-1:0] known_nx  [NWORDS];

  logic [ADD_W-1:0] pairs;
  logic [SUM_W-1:0] chk_sum;
  logic             any_mis;
  logic [CH_W-1:0]  cap_chan;
  logic [WD_W-1:0]  cap_word;
  logic [BYTES-1:0] cap_bmask;
  logic [XLEN-1:0]  cap_exp;
  logic [XLEN-1:0]  cap_act;
  logic [BYTES-1:0] rm, wm, cmp, mis;
  logic [XLEN-1:0]  rd, wd;

  // NOTE: blocking updates to shadow_nx/known_nx inside the loop are deliberate:
  // a higher channel must see what lower channels stored in the same cycle.
  always_comb begin
    // NOTE: every variable gets a default up front so no path infers a latch.
    shadow_nx = shadow_q;
    known_nx  = known_q;
    pairs     = '0;
    any_mis   = 1'b0;
    cap_chan  = '0;
    cap_word  = '0;
    cap_bmask = '0;
    cap_exp   = '0;
    cap_act   = '0;
    rm = '0; wm = '0; cmp = '0; mis = '0; rd = '0; wd = '0;
    for (int c = 0; c < NRET; c++) begin
      for (int w = 0; w < NWORDS; w++) begin
        if (rvfi_valid[c] &&
            (((rvfi_mem_addr[c*XLEN +: XLEN] ^ track_addr[w*XLEN +: XLEN]) & ADDR_MASK) == '0)) begin
          rm  = rvfi_mem_rmask[c*BYTES +: BYTES];
          wm  = rvfi_mem_wmask[c*BYTES +: BYTES];
          rd  = rvfi_mem_rdata[c*XLEN +: XLEN];
          wd  = rvfi_mem_wdata[c*XLEN +: XLEN];
          cmp = rm & known_nx[w];
          mis = '0;
          for (int i = 0; i < BYTES; i++) begin
            if (cmp[i] && (rd[i*8 +: 8] != shadow_nx[w][i*8 +: 8])) mis[i] = 1'b1;
          end
          if (|cmp) pairs = pairs + ADD_W'(1);
          // Loop order gives lowest channel, then lowest entry, as the capture.
          if ((|mis) && !any_mis) begin
            cap_chan  = CH_W'(c);
            cap_word  = WD_W'(w);
            cap_bmask = mis;
            cap_exp   = shadow_nx[w];
            cap_act   = rd;
          end
          if (|mis) any_mis = 1'b1;
          // Read side is settled above; now seed unknown bytes, then apply stores.
          for (int i = 0; i < BYTES; i++) begin
            if ((INIT_ON_READ != 0) && rm[i] && !known_nx[w][i]) begin
              shadow_nx[w][i*8 +: 8] = rd[i*8 +: 8];
              known_nx[w][i]         = 1'b1;
            end
            if (wm[i]) begin
              shadow_nx[w][i*8 +: 8] = wd[i*8 +: 8];
              known_nx[w][i]         = 1'b1;
            end
          end
        end
      end
    end
    chk_sum = SUM_W'(check_cnt) + SUM_W'(pairs);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the shadow array is cleared on reset because a stale known bit
      // would otherwise produce false mismatches after reset.
      for (int w = 0; w < NWORDS; w++) begin
        shadow_q[w] <= '0;
        known_q[w]  <= '0;
      end
      err          <= 1'b0;
      err_chan     <= '0;
      err_word     <= '0;
      err_bmask    <= '0;
      err_expected <= '0;
      err_actual   <= '0;
      check_cnt    <= '0;
      err_cnt      <= '0;
    end else begin
      shadow_q <= shadow_nx;
      known_q  <= known_nx;
      if (any_mis && !err) begin
        err          <= 1'b1;
        err_chan     <= cap_chan;
        err_word     <= cap_word;
        err_bmask    <= cap_bmask;
        err_expected <= cap_exp;
        err_actual   <= cap_act;
      end
      check_cnt <= (chk_sum > SUM_W'(CNT_MAX)) ? CNT_MAX : chk_sum[CNT_W-1:0];
      if (any_mis && (err_cnt != CNT_MAX)) err_cnt <= err_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_rvfi_dmem_check_multi.sv
// Directed bench for rvfi_dmem_check_multi: single-channel seeding and no-seed
// variants plus a two-channel, 2-bit-counter variant with duplicated entries.
module tb_rvfi_dmem_check_multi;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Single-channel stimulus, shared by the seeding (a) and no-seed (c) instances.
  logic [0:0]   a_valid;
  logic [31:0]  a_addr, a_rdata, a_wdata;
  logic [3:0]   a_rmask, a_wmask;
  logic [127:0] a_track = {32'h400, 32'h300, 32'h200, 32'h100};

  logic        a_err, c_err;
  logic [0:0]  a_chan, c_chan;
  logic [1:0]  a_word, c_word;
  logic [3:0]  a_bmask, c_bmask;
  logic [31:0] a_exp, a_act, c_exp, c_act;
  logic [15:0] a_chk, a_ecnt, c_chk, c_ecnt;

  // Two-channel stimulus; both tracked entries alias the same word.
  logic [1:0]  b_valid;
  logic [63:0] b_addr, b_rdata, b_wdata;
  logic [7:0]  b_rmask, b_wmask;
  logic [63:0] b_track = {32'h100, 32'h100};

  logic        b_err;
  logic [0:0]  b_chan, b_word;
  logic [3:0]  b_bmask;
  logic [31:0] b_exp, b_act;
  logic [1:0]  b_chk, b_ecnt;

  rvfi_dmem_check_multi #(.XLEN(32), .NRET(1), .NWORDS(4), .INIT_ON_READ(1), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .rvfi_valid(a_valid), .rvfi_mem_addr(a_addr),
    .rvfi_mem_rmask(a_rmask), .rvfi_mem_wmask(a_wmask), .rvfi_mem_rdata(a_rdata),
    .rvfi_mem_wdata(a_wdata), .track_addr(a_track), .err(a_err), .err_chan(a_chan),
    .err_word(a_word), .err_bmask(a_bmask), .err_expected(a_exp), .err_actual(a_act),
    .check_cnt(a_chk), .err_cnt(a_ecnt));

  rvfi_dmem_check_multi #(.XLEN(32), .NRET(1), .NWORDS(4), .INIT_ON_READ(0), .CNT_W(16)) u_c (
    .clk(clk), .reset(reset), .rvfi_valid(a_valid), .rvfi_mem_addr(a_addr),
    .rvfi_mem_rmask(a_rmask), .rvfi_mem_wmask(a_wmask), .rvfi_mem_rdata(a_rdata),
    .rvfi_mem_wdata(a_wdata), .track_addr(a_track), .err(c_err), .err_chan(c_chan),
    .err_word(c_word), .err_bmask(c_bmask), .err_expected(c_exp), .err_actual(c_act),
    .check_cnt(c_chk), .err_cnt(c_ecnt));

  rvfi_dmem_check_multi #(.XLEN(32), .NRET(2), .NWORDS(2), .INIT_ON_READ(1), .CNT_W(2)) u_b (
    .clk(clk), .reset(reset), .rvfi_valid(b_valid), .rvfi_mem_addr(b_addr),
    .rvfi_mem_rmask(b_rmask), .rvfi_mem_wmask(b_wmask), .rvfi_mem_rdata(b_rdata),
    .rvfi_mem_wdata(b_wdata), .track_addr(b_track), .err(b_err), .err_chan(b_chan),
    .err_word(b_word), .err_bmask(b_bmask), .err_expected(b_exp), .err_actual(b_act),
    .check_cnt(b_chk), .err_cnt(b_ecnt));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic drv_a(input logic v, input logic [31:0] addr, input logic [3:0] rm,
                       input logic [31:0] rd, input logic [3:0] wm, input logic [31:0] wd);
    a_valid = v; a_addr = addr; a_rmask = rm; a_rdata = rd; a_wmask = wm; a_wdata = wd;
  endtask

  task automatic drv_b(input int c, input logic v, input logic [31:0] addr, input logic [3:0] rm,
                       input logic [31:0] rd, input logic [3:0] wm, input logic [31:0] wd);
    b_valid[c]         = v;
    b_addr[c*32 +: 32] = addr;
    b_rmask[c*4 +: 4]  = rm;
    b_rdata[c*32 +: 32] = rd;
    b_wmask[c*4 +: 4]  = wm;
    b_wdata[c*32 +: 32] = wd;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset coincides with a valid store, which must be ignored.
    reset = 1'b1;
    drv_a(1'b1, 32'h100, 4'h0, 32'h0, 4'hF, 32'h12345678);
    drv_b(0, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0);
    drv_b(1, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0);
    step;
    check("rst_a_err", a_err, 0);
    check("rst_a_chk", a_chk, 0);
    check("rst_a_ecnt", a_ecnt, 0);
    check("rst_a_bmask", a_bmask, 0);
    check("rst_a_exp", a_exp, 0);
    check("rst_b_err", b_err, 0);
    check("rst_b_chk", b_chk, 0);

    // Load that disagrees with the discarded store only seeds the shadow.
    reset = 1'b0;
    drv_a(1'b1, 32'h100, 4'hF, 32'hCAFEF00D, 4'h0, 32'h0);
    step;
    check("post_rst_a_err", a_err, 0);
    check("post_rst_a_chk", a_chk, 0);
    check("post_rst_a_ecnt", a_ecnt, 0);
    check("post_rst_c_err", c_err, 0);

    // Store then matching load.
    drv_a(1'b1, 32'h100, 4'h0, 32'h0, 4'hF, 32'hDEADBEEF);
    step;
    drv_a(1'b1, 32'h100, 4'hF, 32'hDEADBEEF, 4'h0, 32'h0);
    step;
    check("match_a_err", a_err, 0);
    check("match_a_chk", a_chk, 1);
    check("match_c_chk", c_chk, 1);

    // Single-byte load at an unaligned address within the same word.
    drv_a(1'b1, 32'h102, 4'h4, 32'h00AA0000, 4'h0, 32'h0);
    step;
    check("mis_a_err", a_err, 1);
    check("mis_a_bmask", a_bmask, 4'h4);
    check("mis_a_exp", a_exp, 32'hDEADBEEF);
    check("mis_a_act", a_act, 32'h00AA0000);
    check("mis_a_ecnt", a_ecnt, 1);
    check("mis_a_word", a_word, 0);
    check("mis_a_chk", a_chk, 2);
    check("mis_c_err", c_err, 1);

    // Mid-run reset clears everything.
    drv_a(1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0);
    reset = 1'b1;
    step;
    reset = 1'b0;
    check("rst2_a_err", a_err, 0);
    check("rst2_a_chk", a_chk, 0);
    check("rst2_a_ecnt", a_ecnt, 0);
    check("rst2_a_bmask", a_bmask, 0);

    // Seed-on-read vs never-checked unwritten bytes.
    drv_a(1'b1, 32'h200, 4'hF, 32'h5, 4'h0, 32'h0);
    step;
    check("seed_a_err", a_err, 0);
    check("seed_a_chk", a_chk, 0);
    drv_a(1'b1, 32'h200, 4'hF, 32'h6, 4'h0, 32'h0);
    step;
    check("seed2_a_err", a_err, 1);
    check("seed2_a_word", a_word, 1);
    check("seed2_a_bmask", a_bmask, 4'h1);
    check("seed2_a_exp", a_exp, 32'h5);
    check("seed2_a_act", a_act, 32'h6);
    check("seed2_a_chk", a_chk, 1);
    check("seed2_c_err", c_err, 0);
    check("seed2_c_chk", c_chk, 0);

    // Load and store in one retirement: the load sees the old value.
    drv_a(1'b1, 32'h300, 4'h0, 32'h0, 4'hF, 32'hA5A5A5A5);
    step;
    drv_a(1'b1, 32'h300, 4'hF, 32'h11111111, 4'hF, 32'h22222222);
    step;
    check("rw_a_ecnt", a_ecnt, 2);
    check("rw_a_chk", a_chk, 2);
    check("rw_a_word_kept", a_word, 1);
    check("rw_a_exp_kept", a_exp, 32'h5);
    check("rw_c_err", c_err, 1);
    check("rw_c_word", c_word, 2);
    check("rw_c_bmask", c_bmask, 4'hF);
    check("rw_c_exp", c_exp, 32'hA5A5A5A5);
    check("rw_c_act", c_act, 32'h11111111);

    // Invalid retirement must not store; next load still matches the earlier store.
    drv_a(1'b0, 32'h300, 4'hF, 32'h0, 4'hF, 32'h0);
    step;
    drv_a(1'b1, 32'h300, 4'hF, 32'h22222222, 4'h0, 32'h0);
    step;
    check("inv_a_ecnt", a_ecnt, 2);
    check("inv_a_chk", a_chk, 3);
    check("inv_c_ecnt", c_ecnt, 1);
    check("inv_c_chk", c_chk, 2);
    drv_a(1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0);

    // Two channels: ch1 sees ch0's same-cycle store in both aliased entries.
    drv_b(0, 1'b1, 32'h100, 4'h0, 32'h0, 4'hF, 32'h11223344);
    drv_b(1, 1'b1, 32'h100, 4'hF, 32'h11223344, 4'h0, 32'h0);
    step;
    check("b_fwd_err", b_err, 0);
    check("b_fwd_chk", b_chk, 2);
    drv_b(1, 1'b1, 32'h100, 4'hF, 32'h0, 4'h0, 32'h0);
    step;
    check("b_mis_err", b_err, 1);
    check("b_mis_chan", b_chan, 1);
    check("b_mis_word", b_word, 0);
    check("b_mis_bmask", b_bmask, 4'hF);
    check("b_mis_exp", b_exp, 32'h11223344);
    check("b_mis_act", b_act, 32'h0);
    check("b_mis_ecnt", b_ecnt, 1);
    check("b_chk_sat", b_chk, 3);

    // Further mismatches on ch0 saturate err_cnt and leave captures alone.
    drv_b(0, 1'b1, 32'h100, 4'hF, 32'hFFFFFFFF, 4'h0, 32'h0);
    drv_b(1, 1'b0, 32'h0, 4'h0, 32'h0, 4'h0, 32'h0);
    step;
    check("b_ecnt2", b_ecnt, 2);
    step;
    check("b_ecnt3", b_ecnt, 3);
    step;
    check("b_ecnt_sat", b_ecnt, 3);
    check("b_chan_kept", b_chan, 1);
    check("b_act_kept", b_act, 32'h0);
    check("b_exp_kept", b_exp, 32'h11223344);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rvfi_dmem_check_multi.md
RVFI_DMEM_CHECK_MULTI -- requirements
Module: rvfi_dmem_check_multi

Interface
REQ-001 SHALL have parameter XLEN, default 32, data/address width in bits (32 or 64).
REQ-002 SHALL have parameter NRET, default 1, number of retirement channels.
REQ-003 SHALL have parameter NWORDS, default 4, number of tracked memory words.
REQ-004 SHALL have parameter INIT_ON_READ, default 1; 1 = first read of an unwritten byte seeds the shadow, 0 = unwritten bytes are never checked.
REQ-005 SHALL have parameter CNT_W, default 16, counter width.
REQ-006 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-007 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-008 SHALL have ports rvfi_valid, rvfi_mem_addr, rvfi_mem_rmask, rvfi_mem_wmask, rvfi_mem_rdata, rvfi_mem_wdata  input  NRET, NRET*XLEN, NRET*XLEN/8, NRET*XLEN/8, NRET*XLEN, NRET*XLEN  RVFI memory fields, channel c in slice c.
REQ-009 SHALL have port track_addr  input  NWORDS*XLEN  tracked word addresses, entry w in slice w; held stable by the environment.
REQ-010 SHALL have port err  output  1  sticky mismatch flag.
REQ-011 SHALL have ports err_chan, err_word  output  $clog2(NRET) max 1, $clog2(NWORDS) max 1  channel and entry of the first mismatch.
REQ-012 SHALL have ports err_bmask  output  XLEN/8, err_expected, err_actual  output  XLEN  first-mismatch byte mask, shadow value, rdata value.
REQ-013 SHALL have ports check_cnt, err_cnt  output  CNT_W  saturating counters.

Function
REQ-014 SHALL hold per entry w an XLEN-bit shadow and an XLEN/8-bit known mask.
REQ-015 SHALL treat channel c as matching entry w when rvfi_valid[c]=1 and mem_addr[c] equals track_addr[w] with the low log2(XLEN/8) bits of both ignored.
REQ-016 SHALL process channels in ascending index within a cycle; channel c observes shadow/known updates made by channels < c in the same cycle.
REQ-017 SHALL, per matching (c,w), evaluate reads before writes of the same channel.
REQ-018 SHALL flag byte i mismatched when rmask[c][i]=1, known[w][i]=1, and rdata byte i of channel c differs from shadow byte i.
REQ-019 SHALL, when rmask[c][i]=1, known[w][i]=0 and INIT_ON_READ=1, load shadow byte i from rdata and set known[w][i]; no mismatch.
REQ-020 SHALL, when wmask[c][i]=1, load shadow byte i from wdata of channel c and set known[w][i].
REQ-021 SHALL update every matching entry independently when several entries share an address.
REQ-022 SHALL register all state and outputs; a retirement at edge N is reflected on outputs after edge N (1-cycle latency).
REQ-023 SHALL add to check_cnt the number of (c,w) pairs with at least one compared byte per cycle, saturating at 2^CNT_W-1.
REQ-024 SHALL increment err_cnt by 1 per cycle containing any mismatch, saturating at 2^CNT_W-1.
REQ-025 SHALL, on the first mismatching cycle while err=0, set err and capture err_chan, err_word (lowest c, then lowest w), err_bmask, err_expected, err_actual; later mismatches leave captures unchanged.
REQ-026 SHALL ignore rmask/wmask on channels with rvfi_valid=0.

Reset
REQ-027 SHALL, while reset=1 at a rising edge, clear all known masks, shadows, err, captures and both counters to 0, ignoring concurrent RVFI inputs.
REQ-028 SHALL resume checking on the first edge with reset=0, with all bytes unknown.

Verification
REQ-029 SHALL cover: XLEN=32, track_addr[0]=0x100; ch0 write 0x100 wmask=F wdata=0xDEADBEEF, next cycle read rmask=F rdata=0xDEADBEEF -> err=0, check_cnt=1.
REQ-030 SHALL cover: same write, then read 0x102 rmask=0x4 rdata=0x00AA0000 -> err=1, err_bmask=0x4, err_expected=0xDEADBEEF, err_actual=0x00AA0000, err_cnt=1.
REQ-031 SHALL cover: NRET=2, same cycle ch0 write 0x100 wdata=0x11223344 wmask=F and ch1 read 0x100 rdata=0x11223344 -> err=0; ch1 rdata=0x0 -> err=1, err_chan=1.
REQ-032 SHALL cover: INIT_ON_READ=1, no writes, read 0x100 rdata=0x5 then read rdata=0x6 -> err=1 after second read; INIT_ON_READ=0 -> err=0, check_cnt=0.
REQ-033 SHALL cover: err_cnt forced near 2^CNT_W-1 with CNT_W=2, four mismatching cycles -> err_cnt=3, captures from first mismatch.
REQ-034 SHALL cover: reset=1 asserted coincident with valid write, then read mismatching that write -> err=0, counters=0.
